// File: rtl/up16_io_pkg.sv
// Shared constants and state encoding for the UP16 serial I/O blocks.
package up16_io_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int FRAME_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to the line idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/kbd_uart_rx.sv
// 8N1 keyboard serial receiver presenting a byte and input-ready flag to the UP16 CPU.
//   state     | meaning
//   IDLE      | line idle, waiting for rxs low
//   START     | half-bit check that the start bit is real
//   DATA      | sampling 8 data bits mid-bit, LSB first
//   STOP      | sampling stop bit; high commits, low is a frame error
//   WAIT_IDLE | after a frame error, waiting for the line to return high
module kbd_uart_rx
  import up16_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       rxd,
  input  logic       inp_ack,
  output logic [7:0] keyboard,
  output logic       fgi,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic rxs;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             commit_q, commit_d;
  logic             fe_set;
  logic [7:0]       keyboard_q, keyboard_d;
  logic             fgi_q, fgi_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk_i  (clkin),
    .rst_n_i(rst),
    .d_i    (rxd),
    .q_o    (rxs)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    commit_d = 1'b0;
    fe_set   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rxs) begin
            commit_d = 1'b1;
            state_d  = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A commit landing with inp_ack wins: the new byte stays pending, only the error flags clear.
  always_comb begin
    keyboard_d  = commit_q ? shift_q : keyboard_q;
    fgi_d       = commit_q | (fgi_q & ~inp_ack);
    overrun_d   = (commit_q & fgi_q & ~inp_ack) | (overrun_q & ~inp_ack);
    frame_err_d = fe_set | (frame_err_q & ~inp_ack);
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      keyboard_q  <= '0;
      fgi_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      keyboard_q  <= keyboard_d;
      fgi_q       <= fgi_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign keyboard  = keyboard_q;
  assign fgi       = fgi_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_kbd_uart_rx.sv
// Directed bench for kbd_uart_rx: frames driven on rxd, expected bytes queued and checked after each frame.
module tb_kbd_uart_rx;

  localparam int C   = 16;
  localparam int LAT = 9 * C + C / 2 + 3;

  logic       clkin = 1'b0;
  logic       rst;
  logic       rxd;
  logic       inp_ack;
  logic [7:0] keyboard;
  logic       fgi;
  logic       frame_err;
  logic       overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_start = 0;
  int rise_cyc = -1;
  logic fgi_prev = 1'b0;
  logic [7:0] exp_q[$];

  kbd_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .rxd      (rxd),
    .inp_ack  (inp_ack),
    .keyboard (keyboard),
    .fgi      (fgi),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  always @(negedge clkin) begin
    if (fgi && !fgi_prev) rise_cyc = cyc;
    fgi_prev = fgi;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Optionally pulses inp_ack in exactly the cycle the receiver commits the byte.
  task automatic send_frame(input logic [7:0] b, input int stop_bits, input logic stop_val,
                            input bit ack_at_commit);
    if (stop_val) exp_q.push_back(b);
    last_start = cyc + 1;
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(C);
    end
    rxd = stop_val;
    for (int i = 0; i < C * stop_bits; i++) begin
      inp_ack = ack_at_commit && (cyc == last_start + LAT - 1);
      tick(1);
    end
    inp_ack = 1'b0;
    rxd = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk(tag, keyboard, e);
  endtask

  task automatic pulse_ack();
    inp_ack = 1'b1;
    tick(1);
    inp_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] partial;
    rst = 1'b0;
    rxd = 1'b1;
    inp_ack = 1'b0;
    tick(3);
    chk("rst_keyboard", keyboard, 8'h00);
    chk("rst_fgi", fgi, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b1;
    tick(2 * C);

    rise_cyc = -1;
    send_frame(8'h77, 1, 1'b1, 1'b0);
    check_rx("rx_77");
    chk("fgi_77", fgi, 1'b1);
    chk("fe_77", frame_err, 1'b0);
    chk("ov_77", overrun, 1'b0);
    chk("latency_77", rise_cyc - last_start, LAT);
    tick(C);

    pulse_ack();
    chk("ack_fgi", fgi, 1'b0);
    chk("ack_keyboard_hold", keyboard, 8'h77);
    pulse_ack();
    chk("idle_ack_fgi", fgi, 1'b0);
    chk("idle_ack_keyboard", keyboard, 8'h77);
    tick(C);

    send_frame(8'h99, 1, 1'b1, 1'b0);
    check_rx("rx_99");
    send_frame(8'h88, 1, 1'b1, 1'b0);
    check_rx("rx_88_overwrite");
    chk("fgi_88", fgi, 1'b1);
    chk("overrun_set", overrun, 1'b1);
    tick(C);
    pulse_ack();
    chk("overrun_clr", overrun, 1'b0);
    chk("overrun_fgi_clr", fgi, 1'b0);
    tick(C);

    send_frame(8'hEE, 3, 1'b0, 1'b0);
    tick(C);
    chk("fe_set", frame_err, 1'b1);
    chk("fe_fgi_hold", fgi, 1'b0);
    chk("fe_keyboard_hold", keyboard, 8'h88);
    send_frame(8'h11, 1, 1'b1, 1'b0);
    check_rx("rx_11_after_fe");
    chk("fgi_11", fgi, 1'b1);
    chk("fe_sticky", frame_err, 1'b1);
    tick(C);
    pulse_ack();
    chk("fe_clr", frame_err, 1'b0);
    tick(C);

    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(2 * C);
    chk("glitch_fgi", fgi, 1'b0);
    send_frame(8'h3C, 1, 1'b1, 1'b0);
    check_rx("rx_3C_after_glitch");
    chk("fgi_3C", fgi, 1'b1);
    tick(C);
    send_frame(8'hC3, 1, 1'b1, 1'b1);
    check_rx("rx_C3_ack_commit");
    chk("ack_commit_fgi", fgi, 1'b1);
    chk("ack_commit_ov", overrun, 1'b0);
    tick(C);

    partial = 8'hA5;
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rxd = partial[i];
      tick(C);
    end
    rxd = partial[4];
    tick(C / 2);
    rst = 1'b0;
    #1;
    chk("midrst_keyboard", keyboard, 8'h00);
    chk("midrst_fgi", fgi, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    rxd = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2 * C);
    rise_cyc = -1;
    send_frame(8'h5A, 1, 1'b1, 1'b0);
    check_rx("rx_5A_after_rst");
    chk("fgi_5A", fgi, 1'b1);
    chk("latency_5A", rise_cyc - last_start, LAT);
    tick(C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
